// File: rtl/div32_seq.sv
// Sequential 32-bit divider for RISC-V DIV/DIVU/REM/REMU: one restoring step per cycle,
// with a two-edge fast path for divide-by-zero and signed overflow.
module div32_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] S,
    output logic        busy,
    output logic        done,
    output logic        dbz
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] s_q, s_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    logic        in_signed;
    logic        in_fast;
    logic [31:0] in_a_mag;
    logic        signed_op;
    logic [31:0] b_mag;
    logic        zero_div;
    logic        overflow;
    logic [32:0] sh;
    logic [32:0] diff;
    logic        cout;
    logic        unused_diff_msb;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] result;

    assign in_signed = ~op[0];
    assign in_fast   = (B == 32'd0) ||
                       (in_signed && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF));
    assign in_a_mag  = (in_signed && A[31]) ? (~A + 32'd1) : A;

    assign signed_op = ~op_q[0];
    assign b_mag     = (signed_op && b_q[31]) ? (~b_q + 32'd1) : b_q;
    assign zero_div  = (b_q == 32'd0);
    assign overflow  = signed_op && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

    // Trial subtract as A + ~B + 1; a carry-out of 1 means no borrow, so the step succeeds.
    assign sh              = {rem_q, quo_q[31]};
    assign {cout, diff}    = {1'b0, sh} + {1'b0, ~{1'b0, b_mag}} + 34'd1;
    assign unused_diff_msb = diff[32];

    assign quo_fix = (signed_op && (a_q[31] ^ b_q[31])) ? (~quo_q + 32'd1) : quo_q;
    assign rem_fix = (signed_op && a_q[31]) ? (~rem_q + 32'd1) : rem_q;

    always_comb begin
        result = op_q[1] ? rem_fix : quo_fix;
        if (zero_div) begin
            result = op_q[1] ? a_q : 32'hFFFF_FFFF;
        end else if (overflow) begin
            result = op_q[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = op;
                    rem_d   = 32'd0;
                    quo_d   = in_a_mag;
                    cnt_d   = 5'd0;
                    dbz_d   = 1'b0;
                    state_d = in_fast ? FIX : RUN;
                end
            end
            RUN: begin
                rem_d = cout ? diff[31:0] : sh[31:0];
                quo_d = {quo_q[30:0], cout};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                s_d     = result;
                dbz_d   = zero_div;
                done_d  = 1'b1;
                cnt_d   = 5'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 2'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            cnt_q   <= 5'd0;
            s_q     <= 32'd0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign S    = s_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign dbz  = dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: table vectors, hand-written handshake/reset sequences
// and a reference-model sweep, all scored through an expected-result queue.
module tb_div32_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] S;
    logic        busy;
    logic        done;
    logic        dbz;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_s;
        logic        exp_dbz;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] s;
        logic        dbz;
        int          lat;
        int          c0;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[14];
    logic [31:0] specials[5];
    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    int          doneCount = 0;
    logic [31:0] lastS = 32'd0;

    div32_seq dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .op(op),
        .A(A),
        .B(B),
        .S(S),
        .busy(busy),
        .done(done),
        .dbz(dbz)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Independent RISC-V M reference, built on the simulator's own signed/unsigned arithmetic.
    task automatic refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] s, output logic d, output int lat);
        int  sa;
        int  sbv;
        logic ovf;
        sa  = a;
        sbv = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF) && !o[0];
        d   = (b == 32'd0);
        lat = (d || ovf) ? 2 : 34;
        case (o)
            2'd0: s = d ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sbv));
            2'd1: s = d ? 32'hFFFF_FFFF : (a / b);
            2'd2: s = d ? a : (ovf ? 32'd0 : 32'(sa % sbv));
            default: s = d ? a : (a % b);
        endcase
    endtask

    // Scoreboard consumer: every done pops one expectation and checks result, flag and latency.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && done) begin
            doneCount++;
            checkOutput("done_with_busy", {31'd0, busy}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done actual=1 expected=0");
            end else begin
                e = sb.pop_front();
                checkOutput("S", S, e.s);
                checkOutput("dbz", {31'd0, dbz}, {31'd0, e.dbz});
                checkOutput("latency", 32'(cycle - e.c0 + 1), 32'(e.lat));
            end
        end
    end

    // Called at a negedge; returns just after the start edge with the expectation queued.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] s_exp, input logic d_exp, input int lat_exp);
        exp_t e;
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        op    = 2'($urandom_range(0, 3));
        checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
        checkOutput("dbz_clear_on_start", {31'd0, dbz}, 32'd0);
        checkOutput("S_hold_on_start", S, lastS);
        e.s   = s_exp;
        e.dbz = d_exp;
        e.lat = lat_exp;
        e.c0  = cycle;
        sb.push_back(e);
        lastS = s_exp;
    endtask

    // Returns at the negedge where done is high, so a following launch is back-to-back.
    task automatic waitDone();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout actual=0 expected=1");
            sb.delete();
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            lastS = 32'd0;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] s_exp, input logic d_exp, input int lat_exp);
        launch(o, a, b, s_exp, d_exp, lat_exp);
        waitDone();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] es;
        logic        ed;
        int          el;
        int          doneBefore;

        vecs[0]  = '{2'd1, 32'd100,        32'd7,          32'd14,         1'b0, 34};
        vecs[1]  = '{2'd3, 32'd100,        32'd7,          32'd2,          1'b0, 34};
        vecs[2]  = '{2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 34};
        vecs[3]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, 34};
        vecs[4]  = '{2'd1, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, 2};
        vecs[5]  = '{2'd2, 32'd5,          32'd0,          32'd5,          1'b1, 2};
        vecs[6]  = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 2};
        vecs[7]  = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, 2};
        vecs[8]  = '{2'd1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, 34};
        vecs[9]  = '{2'd0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0, 34};
        vecs[10] = '{2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, 34};
        vecs[11] = '{2'd1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, 34};
        vecs[12] = '{2'd0, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, 2};
        vecs[13] = '{2'd3, 32'hFFFF_FFFF,  32'h10,         32'hF,          1'b0, 34};

        specials[0] = 32'h8000_0000;
        specials[1] = 32'h7FFF_FFFF;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h0000_0001;
        specials[4] = 32'h0000_0000;

        reset = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        A     = 32'd0;
        B     = 32'd0;
        #3;
        checkOutput("reset_S", S, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_dbz", {31'd0, dbz}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_s, vecs[i].exp_dbz, vecs[i].exp_lat);
        end

        // start pulses while busy must not disturb the running operation.
        @(negedge clock);
        launch(2'd1, 32'd100, 32'd7, 32'd14, 1'b0, 34);
        repeat (5) @(negedge clock);
        op    = 2'd0;
        A     = 32'd999;
        B     = 32'd1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        waitDone();

        // Abort mid-operation with an asynchronous reset, then prove no stale done appears.
        @(negedge clock);
        launch(2'd1, 32'd1000, 32'd3, 32'd333, 1'b0, 34);
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_S", S, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        sb.delete();
        lastS = 32'd0;
        @(negedge clock);
        op    = 2'd1;
        A     = 32'd50;
        B     = 32'd5;
        start = 1'b1;
        @(negedge clock);
        checkOutput("start_in_reset_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        reset = 1'b0;
        doneBefore = doneCount;
        repeat (40) @(negedge clock);
        checkOutput("no_done_after_abort", 32'(doneCount - doneBefore), 32'd0);
        applyStimulus(2'd1, 32'd50, 32'd5, 32'd10, 1'b0, 34);

        for (int o = 0; o < 4; o++) begin
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 5; j++) begin
                    refModel(2'(o), specials[i], specials[j], es, ed, el);
                    applyStimulus(2'(o), specials[i], specials[j], es, ed, el);
                end
            end
        end

        for (int k = 0; k < 150; k++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = 32'($urandom_range(0, 255));
            rb = 32'($urandom_range(0, 255));
            refModel(ro, ra, rb, es, ed, el);
            applyStimulus(ro, ra, rb, es, ed, el);
        end

        for (int k = 0; k < 60; k++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (k % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            refModel(ro, ra, rb, es, ed, el);
            applyStimulus(ro, ra, rb, es, ed, el);
        end

        repeat (3) @(negedge clock);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div32_seq.md
DIV32_SEQ -- requirements
Module: div32_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be as listed in REQ-002 to REQ-011.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 op  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU (RISC-V M semantics).
REQ-006 A  input  32  dividend; sampled on the start edge.
REQ-007 B  input  32  divisor; sampled on the start edge.
REQ-008 S  output  32  registered result (quotient or remainder).
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse marking S valid.
REQ-011 dbz  output  1  high with done when B was zero; held with S.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and FIX.
REQ-013 In IDLE with start=1, edge E0 SHALL latch A, B and op, set busy=1, and enter RUN.
REQ-013a In IDLE with start=1 and the fast path of REQ-018 or REQ-019 applicable, edge E0 SHALL enter FIX directly.
REQ-014 RUN SHALL perform one restoring-division step per edge, for edges E1..E32.
REQ-014a Each RUN step SHALL shift {rem,quo} left by 1 and trial-subtract the 33-bit value rem-|B| using the same two's-complement rule as adder32b with SUB=1 (A + ~B + 1).
REQ-014b A RUN step SHALL keep the difference and set the quotient LSB to 1 when the carry-out is 1 (no borrow); otherwise it SHALL keep rem and set the quotient LSB to 0.
REQ-015 An iteration counter of 5 bits SHALL count 0..31, and RUN SHALL exit to FIX after the 32nd step.
REQ-016 For signed ops, the datapath SHALL divide magnitudes |A| and |B|.
REQ-016a FIX SHALL negate the quotient when sign(A)≠sign(B), and SHALL give the remainder the sign of A.
REQ-017 At the FIX edge (E33 on the normal path), S SHALL load the selected result, done SHALL go to 1 for one cycle, busy SHALL go to 0, and the FSM SHALL return to IDLE.
REQ-018 Divide by zero SHALL take a fast path: E0 enters FIX and E1 completes the operation.
REQ-018a On divide by zero, the quotient SHALL be 0xFFFFFFFF, the remainder SHALL be A, and dbz SHALL be 1.
REQ-019 Signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF) SHALL take the fast path of REQ-018.
REQ-019a On signed overflow, the quotient SHALL be 0x80000000, the remainder SHALL be 0, and dbz SHALL be 0.
REQ-020 Latency SHALL be 34 edges from the start edge to done on the normal path, and 2 edges on the fast path.
REQ-021 start SHALL be ignored while busy=1, and A, B and op SHALL not be resampled during that time.
REQ-022 start asserted in the same cycle that done=1 SHALL be accepted (the FSM is in IDLE), giving back-to-back operations with no dead cycle.
REQ-023 S and dbz SHALL hold their values from the last done until the next FIX edge.
REQ-023a On the start edge, dbz SHALL clear to 0 and S SHALL stay unchanged.
REQ-024 busy SHALL equal (state≠IDLE); done SHALL never coincide with busy=1.
REQ-025 All arithmetic SHALL be modulo 2^32, except the trial subtract, which SHALL be 33 bits wide.

Reset
REQ-026 reset=1 SHALL force, immediately and regardless of clock: state=IDLE, counter=0, S=0, busy=0, done=0, dbz=0, and the internal registers to 0.
REQ-027 Reset mid-operation SHALL abort the operation without producing done, and the next start after reset release SHALL operate normally.
REQ-028 start SHALL have no effect while reset=1.

Verification
REQ-029 Normal path: op=01, A=100, B=7, start for 1 cycle -> done exactly 34 edges later, S=14, dbz=0; op=11 with the same operands -> S=2.
REQ-030 Signed path: op=00, A=0xFFFFFFF9 (-7), B=2 -> S=0xFFFFFFFD (-3); op=10 with the same operands -> S=0xFFFFFFFF (-1).
REQ-031 Divide by zero: op=01, A=5, B=0 -> done 2 edges after start, S=0xFFFFFFFF, dbz=1; op=10 with the same operands -> S=5, dbz=1.
REQ-032 Signed overflow: op=00, A=0x80000000, B=0xFFFFFFFF -> done after 2 edges, S=0x80000000, dbz=0; op=10 with the same operands -> S=0.
REQ-033 Reset and handshake: reset pulsed after the 10th RUN edge -> busy=0, S=0, done=0 asynchronously and no later done.
REQ-033a start pulsed while busy=1 -> ignored, and the original result is returned.
REQ-033b start held in the done cycle -> a second result arrives 34 edges later.
REQ-034 Sweep: all op values with A,B in 0..255 and A,B in {0x80000000, 0x7FFFFFFF, 0xFFFFFFFF, 1} -> S matches the RISC-V reference model, and the bench SHALL count mismatches and report the total.
